// File: rtl/i2s_codec_intf.sv
// I2S codec interface: derives MCLK/SCLK/LRCLK from a free-running frame counter,
// deserialises ADC slots into 16-bit samples and serialises EQ outputs to the DAC.
module i2s_codec_intf #(
    parameter int DW       = 16,
    parameter int SLOT     = 32,
    parameter int SCLK_DIV = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          MCLK,
    output logic          SCLK,
    output logic          LRCLK,
    input  logic          ADC_SDATA,
    output logic          DAC_SDATA,
    input  logic [DW-1:0] lft_in,
    input  logic [DW-1:0] rht_in,
    output logic [DW-1:0] lft_out,
    output logic [DW-1:0] rht_out,
    output logic          vld
);

    localparam int DV = $clog2(SCLK_DIV);
    localparam int CW = $clog2(2 * SLOT * SCLK_DIV);
    localparam int BW = CW - 1 - DV;
    localparam int IW = $clog2(DW);

    logic [CW-1:0] cnt_r;
    logic [DW-1:0] shift_lft_r;
    logic [DW-1:0] shift_rht_r;
    logic [DW-1:0] shadow_lft_r;
    logic [DW-1:0] shadow_rht_r;
    logic [DW-1:0] lft_out_r;
    logic [DW-1:0] rht_out_r;
    logic          vld_r;
    logic          dac_r;

    logic [BW-1:0] bit_idx_s;
    logic [IW-1:0] tx_idx_s;
    logic          in_data_s;
    logic          capture_s;
    logic          update_s;
    logic          frame_end_s;
    logic          tx_bit_s;

    // Slot decode: data bits occupy b=1..DW, b=0 is the I2S one-bit delay
    always_comb begin
        bit_idx_s   = cnt_r[CW-2:DV];
        in_data_s   = (bit_idx_s != {BW{1'b0}}) && (bit_idx_s <= BW'(DW));
        tx_idx_s    = IW'(BW'(DW) - bit_idx_s);
        capture_s   = (cnt_r[DV-1:0] == DV'(SCLK_DIV * 5 / 8));
        update_s    = (cnt_r[DV-1:0] == {DV{1'b0}});
        frame_end_s = (cnt_r == {CW{1'b1}});
        if (!in_data_s) begin
            tx_bit_s = 1'b0;
        end else if (cnt_r[CW-1]) begin
            tx_bit_s = shadow_rht_r[tx_idx_s];
        end else begin
            tx_bit_s = shadow_lft_r[tx_idx_s];
        end
    end

    // Frame counter; codec clocks are taken straight from its flops
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // ADC deserialiser, sampled mid SCLK-high
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_lft_r <= {DW{1'b0}};
            shift_rht_r <= {DW{1'b0}};
        end else if (capture_s && in_data_s) begin
            if (cnt_r[CW-1]) begin
                shift_rht_r <= {shift_rht_r[DW-2:0], ADC_SDATA};
            end else begin
                shift_lft_r <= {shift_lft_r[DW-1-1:0], ADC_SDATA};
            end
        end
    end

    // Frame boundary: publish captured pair and latch the next DAC pair
    always_ff @(posedge clk) begin
        if (rst) begin
            lft_out_r    <= {DW{1'b0}};
            rht_out_r    <= {DW{1'b0}};
            shadow_lft_r <= {DW{1'b0}};
            shadow_rht_r <= {DW{1'b0}};
            vld_r        <= 1'b0;
        end else if (frame_end_s) begin
            lft_out_r    <= shift_lft_r;
            rht_out_r    <= shift_rht_r;
            shadow_lft_r <= lft_in;
            shadow_rht_r <= rht_in;
            vld_r        <= 1'b1;
        end else begin
            vld_r        <= 1'b0;
        end
    end

    // DAC serialiser, changes on SCLK falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_r <= 1'b0;
        end else if (update_s) begin
            dac_r <= tx_bit_s;
        end
    end

    // Output mapping from registered state
    always_comb begin
        MCLK      = cnt_r[1];
        SCLK      = cnt_r[DV-1];
        LRCLK     = cnt_r[CW-1];
        DAC_SDATA = dac_r;
        lft_out   = lft_out_r;
        rht_out   = rht_out_r;
        vld       = vld_r;
    end

endmodule

// File: tb/tb_i2s_codec_intf.sv
// Directed bench for i2s_codec_intf: codec model on ADC side, bit checker on DAC side,
// frame-by-frame stimulus table with one mid-frame reset.
module tb_i2s_codec_intf;

    logic        clk = 1'b0;
    logic        rst;
    logic        MCLK, SCLK, LRCLK;
    logic        ADC_SDATA;
    logic        DAC_SDATA;
    logic [15:0] lft_in, rht_in;
    logic [15:0] lft_out, rht_out;
    logic        vld;

    int errors = 0;
    int checks = 0;

    i2s_codec_intf dut (
        .clk       (clk),
        .rst       (rst),
        .MCLK      (MCLK),
        .SCLK      (SCLK),
        .LRCLK     (LRCLK),
        .ADC_SDATA (ADC_SDATA),
        .DAC_SDATA (DAC_SDATA),
        .lft_in    (lft_in),
        .rht_in    (rht_in),
        .lft_out   (lft_out),
        .rht_out   (rht_out),
        .vld       (vld)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // per-frame stimulus: ADC words sent by codec, padding level, DAC inputs presented
    logic [15:0] adc_l_t [6];
    logic [15:0] adc_r_t [6];
    logic        pad_t   [6];
    logic [15:0] lin_t   [6];
    logic [15:0] rin_t   [6];

    int          tcnt;
    int          fr;
    int          b;
    logic        vld_e;
    logic [15:0] exp_l, exp_r, tx_l, tx_r, nxt_l, nxt_r, word;
    logic        exp_dac;

    initial begin
        adc_l_t = '{16'h8001, 16'h0000, 16'h5A5A, 16'h0F0F, 16'h0000, 16'h0000};
        adc_r_t = '{16'h7FFE, 16'h0000, 16'hFFFF, 16'h8000, 16'h0000, 16'h0000};
        pad_t   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        lin_t   = '{16'hA5C3, 16'hA5C3, 16'h4444, 16'h7FFF, 16'h0000, 16'h0000};
        rin_t   = '{16'h0001, 16'h0001, 16'h5555, 16'hFFFE, 16'h0000, 16'h0000};

        rst = 1'b1; ADC_SDATA = 1'b0; lft_in = 16'h0000; rht_in = 16'h0000;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        tcnt = 0; fr = 0; vld_e = 1'b0;
        exp_l = 16'h0000; exp_r = 16'h0000; tx_l = 16'h0000; tx_r = 16'h0000;
        nxt_l = 16'h0000; nxt_r = 16'h0000;

        while (!(fr == 5 && tcnt == 100)) begin
            // drive this cycle's inputs
            if (tcnt == 0) begin
                lft_in = lin_t[fr];
                rht_in = rin_t[fr];
            end
            if (fr == 1 && tcnt == 300) lft_in = 16'h1234;
            b = (tcnt >> 4) & 31;
            word = ((tcnt >> 9) & 1) != 0 ? adc_r_t[fr] : adc_l_t[fr];
            ADC_SDATA = (b >= 1 && b <= 16) ? word[16-b] : pad_t[fr];

            // checks against bench model
            check_val("vld", {15'd0, vld}, {15'd0, vld_e});
            check_val("mclk", {15'd0, MCLK}, 16'((tcnt >> 1) & 1));
            check_val("sclk", {15'd0, SCLK}, 16'((tcnt >> 3) & 1));
            check_val("lrclk", {15'd0, LRCLK}, 16'((tcnt >> 9) & 1));
            if ((tcnt % 64) == 0) begin
                check_val("lft_out", lft_out, exp_l);
                check_val("rht_out", rht_out, exp_r);
            end
            if ((tcnt % 16) == 8) begin
                word = ((tcnt >> 9) & 1) != 0 ? tx_r : tx_l;
                exp_dac = (b >= 1 && b <= 16) ? word[16-b] : 1'b0;
                check_val("dac", {15'd0, DAC_SDATA}, {15'd0, exp_dac});
            end

            // advance one clock
            if (fr == 2 && tcnt == 600) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                tcnt = 0; fr = 3; vld_e = 1'b0;
                exp_l = 16'h0000; exp_r = 16'h0000; tx_l = 16'h0000; tx_r = 16'h0000;
                check_val("rst_dac", {15'd0, DAC_SDATA}, 16'h0000);
                check_val("rst_lft", lft_out, 16'h0000);
            end else begin
                if (tcnt == 1023) begin
                    nxt_l = lft_in;
                    nxt_r = rht_in;
                end
                @(posedge clk);
                #1;
                if (tcnt == 1023) begin
                    tcnt = 0;
                    vld_e = 1'b1;
                    exp_l = adc_l_t[fr];
                    exp_r = adc_r_t[fr];
                    tx_l = nxt_l;
                    tx_r = nxt_r;
                    fr++;
                end else begin
                    tcnt++;
                    vld_e = 1'b0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
